// File: rtl/block_mac_sequencer.sv
// Purpose: per-lane sequencer computing C_ij = sum_x A_ix*B_xj (fetch A/B blocks into the RF, run the PU, write C back).
// Latency: per x, 2*K*K+1 granted fetch cycles plus PU time; then K*K+1 granted write cycles and a one-cycle DONE.
// Backpressure: i_Grant low stalls the word counter p; a read or RF read that was already issued still lands one cycle later.
//
// Ports:
//   i_Clock, i_Reset (async, active-low)
//   i_Indexes_Ready / o_Indexes_Received       : job handshake (i, j, mu, stride, region bases)
//   o_Grant_Request / i_Grant                  : memory arbiter handshake
//   o_Mem_Read_En / o_Mem_Write_En / o_Mem_Address
//   o_RF_Write_En / o_RF_Read_En / o_RF_Address : RF (A at 0..K*K-1, B at K*K..2K*K-1, C read from 0..K*K-1)
//   o_PU_Start / i_PU_Done                     : processing unit handshake
//   o_Result_Ready, o_Busy
// Optional: define PU_WATCHDOG_EN to add parameter WATCHDOG_CYCLES and output o_Error
//   (PU timeout aborts to IDLE without o_Result_Ready; o_Error is sticky until reset or the next accepted job).
module block_mac_sequencer #(
    parameter int K             = 2,
    parameter int INDEX_WIDTH   = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int MU_WIDTH      = 8,
    parameter int RF_ADDR_WIDTH = $clog2(2 * K * K)
`ifdef PU_WATCHDOG_EN
    ,
    parameter int WATCHDOG_CYCLES = 1024
`endif
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Indexes_Ready,
    input  logic [INDEX_WIDTH-1:0]   i_Row_Index,
    input  logic [INDEX_WIDTH-1:0]   i_Column_Index,
    input  logic [MU_WIDTH-1:0]      i_mu,
    input  logic [INDEX_WIDTH-1:0]   i_Blocks_Per_Row,
    input  logic [ADDR_WIDTH-1:0]    i_A_Base,
    input  logic [ADDR_WIDTH-1:0]    i_B_Base,
    input  logic [ADDR_WIDTH-1:0]    i_C_Base,
    output logic                     o_Indexes_Received,
    output logic                     o_Result_Ready,
    output logic                     o_Busy,
    output logic                     o_Grant_Request,
    input  logic                     i_Grant,
    output logic                     o_Mem_Read_En,
    output logic                     o_Mem_Write_En,
    output logic [ADDR_WIDTH-1:0]    o_Mem_Address,
    output logic                     o_RF_Write_En,
    output logic                     o_RF_Read_En,
    output logic [RF_ADDR_WIDTH-1:0] o_RF_Address,
    output logic                     o_PU_Start,
`ifdef PU_WATCHDOG_EN
    output logic                     o_Error,
`endif
    input  logic                     i_PU_Done
);

    localparam int KK  = K * K;
    localparam int P_W = (KK > 1) ? $clog2(KK) : 1;
    localparam logic [P_W-1:0]           P_LAST    = P_W'(KK - 1);
    localparam logic [ADDR_WIDTH-1:0]    BLK_WORDS = ADDR_WIDTH'(KK);
    localparam logic [RF_ADDR_WIDTH-1:0] RF_B_OFS  = RF_ADDR_WIDTH'(KK);

    typedef enum logic [3:0] {
        IDLE, REQ_RD, FETCH_A, FETCH_B, DRAIN, PU_RUN, REQ_WR, WRITE, DONE
    } state_t;

    // Job parameters latched on acceptance; last_x = max(mu,1)-1.
    typedef struct packed {
        logic [INDEX_WIDTH-1:0] row;
        logic [INDEX_WIDTH-1:0] col;
        logic [INDEX_WIDTH-1:0] stride;
        logic [MU_WIDTH-1:0]    last_x;
        logic [ADDR_WIDTH-1:0]  a_base;
        logic [ADDR_WIDTH-1:0]  b_base;
        logic [ADDR_WIDTH-1:0]  c_base;
    } job_t;

    state_t                   state_q, state_d;
    job_t                     job_q, job_d;
    logic [MU_WIDTH-1:0]      x_q, x_d;
    logic [P_W-1:0]           p_q, p_d;
    logic                     ack_q, ack_d;
    logic                     rf_wr_q, rf_wr_d;
    logic [RF_ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic                     mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0]    mem_wr_addr_q, mem_wr_addr_d;

    logic                     rd_en, rf_rd_en, start_pls, result_pls, gnt_req;
    logic [ADDR_WIDTH-1:0]    rd_addr;

`ifdef PU_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // Block addresses, all modulo 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0] row_a, col_a, stride_a, x_a, p_a;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr, c_addr;

    assign row_a    = ADDR_WIDTH'(job_q.row);
    assign col_a    = ADDR_WIDTH'(job_q.col);
    assign stride_a = ADDR_WIDTH'(job_q.stride);
    assign x_a      = ADDR_WIDTH'(x_q);
    assign p_a      = ADDR_WIDTH'(p_q);
    assign a_addr   = job_q.a_base + (row_a * stride_a + x_a) * BLK_WORDS + p_a;
    assign b_addr   = job_q.b_base + (x_a * stride_a + col_a) * BLK_WORDS + p_a;
    assign c_addr   = job_q.c_base + (row_a * stride_a + col_a) * BLK_WORDS + p_a;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q       <= IDLE;
            job_q         <= '0;
            x_q           <= '0;
            p_q           <= '0;
            ack_q         <= 1'b0;
            rf_wr_q       <= 1'b0;
            rf_wr_addr_q  <= '0;
            mem_wr_q      <= 1'b0;
            mem_wr_addr_q <= '0;
`ifdef PU_WATCHDOG_EN
            wd_q          <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            x_q           <= x_d;
            p_q           <= p_d;
            ack_q         <= ack_d;
            rf_wr_q       <= rf_wr_d;
            rf_wr_addr_q  <= rf_wr_addr_d;
            mem_wr_q      <= mem_wr_d;
            mem_wr_addr_q <= mem_wr_addr_d;
`ifdef PU_WATCHDOG_EN
            wd_q          <= wd_d;
            err_q         <= err_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        x_d           = x_q;
        p_d           = p_q;
        ack_d         = 1'b0;
        rf_wr_d       = 1'b0;
        rf_wr_addr_d  = '0;
        mem_wr_d      = 1'b0;
        mem_wr_addr_d = '0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        rf_rd_en      = 1'b0;
        start_pls     = 1'b0;
        result_pls    = 1'b0;
        gnt_req       = 1'b0;
`ifdef PU_WATCHDOG_EN
        wd_d          = wd_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_Indexes_Ready) begin
                    job_d.row    = i_Row_Index;
                    job_d.col    = i_Column_Index;
                    job_d.stride = i_Blocks_Per_Row;
                    job_d.last_x = (i_mu == '0) ? '0 : i_mu - MU_WIDTH'(1);
                    job_d.a_base = i_A_Base;
                    job_d.b_base = i_B_Base;
                    job_d.c_base = i_C_Base;
                    x_d          = '0;
                    p_d          = '0;
                    ack_d        = 1'b1;
`ifdef PU_WATCHDOG_EN
                    err_d        = 1'b0;
`endif
                    state_d      = REQ_RD;
                end
            end
            REQ_RD: begin
                gnt_req = 1'b1;
                if (i_Grant) begin
                    p_d     = '0;
                    state_d = FETCH_A;
                end
            end
            FETCH_A: begin
                gnt_req = 1'b1;
                if (i_Grant) begin
                    rd_en        = 1'b1;
                    rd_addr      = a_addr;
                    rf_wr_d      = 1'b1;
                    rf_wr_addr_d = RF_ADDR_WIDTH'(p_q);
                    if (p_q == P_LAST) begin
                        p_d     = '0;
                        state_d = FETCH_B;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end
            end
            FETCH_B: begin
                gnt_req = 1'b1;
                if (i_Grant) begin
                    rd_en        = 1'b1;
                    rd_addr      = b_addr;
                    rf_wr_d      = 1'b1;
                    rf_wr_addr_d = RF_B_OFS + RF_ADDR_WIDTH'(p_q);
                    if (p_q == P_LAST) begin
                        p_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Final B word lands in the RF this cycle; the bus is no longer needed.
                start_pls = 1'b1;
`ifdef PU_WATCHDOG_EN
                wd_d      = '0;
`endif
                state_d   = PU_RUN;
            end
            PU_RUN: begin
                // A done coincident with o_PU_Start was seen in DRAIN and is never looked at.
                if (i_PU_Done) begin
                    if (x_q < job_q.last_x) begin
                        x_d     = x_q + MU_WIDTH'(1);
                        state_d = REQ_RD;
                    end else begin
                        state_d = REQ_WR;
                    end
                end
`ifdef PU_WATCHDOG_EN
                else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            REQ_WR: begin
                gnt_req = 1'b1;
                if (i_Grant) begin
                    p_d     = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                gnt_req = 1'b1;
                if (i_Grant) begin
                    rf_rd_en      = 1'b1;
                    mem_wr_d      = 1'b1;
                    mem_wr_addr_d = c_addr;
                    if (p_q == P_LAST) begin
                        p_d     = '0;
                        state_d = DONE;
                    end else begin
                        p_d = p_q + P_W'(1);
                    end
                end
            end
            DONE: begin
                // The last memory write (RF data from the previous cycle) is on the bus now.
                result_pls = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads are issued only in FETCH_* and delayed writes only land in WRITE/DONE, so the bus mux never collides.
    assign o_Mem_Read_En      = rd_en;
    assign o_Mem_Write_En     = mem_wr_q;
    assign o_Mem_Address      = mem_wr_q ? mem_wr_addr_q : rd_addr;
    assign o_RF_Write_En      = rf_wr_q;
    assign o_RF_Read_En       = rf_rd_en;
    assign o_RF_Address       = rf_rd_en ? RF_ADDR_WIDTH'(p_q) : rf_wr_addr_q;
    assign o_Indexes_Received = ack_q;
    assign o_Result_Ready     = result_pls;
    assign o_PU_Start         = start_pls;
    assign o_Grant_Request    = gnt_req;
    assign o_Busy             = (state_q != IDLE);
`ifdef PU_WATCHDOG_EN
    assign o_Error            = err_q;
`endif

endmodule

// File: tb/tb_block_mac_sequencer.sv
// Purpose: self-checking bench for block_mac_sequencer (directed steps plus randomized jobs vs. an address-list model).
// Latency: n/a (bench).
// Backpressure: grant is driven held, dropped for a window, or randomized.
`timescale 1ns/1ps
module tb_block_mac_sequencer;
    localparam int K  = 2;
    localparam int IW = 8;
    localparam int AW = 10;
    localparam int MW = 8;
    localparam int RW = 3;
    localparam int KK = K * K;

    logic          i_Clock = 1'b0;
    logic          i_Reset = 1'b0;
    logic          i_Indexes_Ready = 1'b0;
    logic [IW-1:0] i_Row_Index = '0;
    logic [IW-1:0] i_Column_Index = '0;
    logic [MW-1:0] i_mu = '0;
    logic [IW-1:0] i_Blocks_Per_Row = '0;
    logic [AW-1:0] i_A_Base = '0;
    logic [AW-1:0] i_B_Base = '0;
    logic [AW-1:0] i_C_Base = '0;
    logic          i_Grant;
    logic          i_PU_Done;
    logic          o_Indexes_Received, o_Result_Ready, o_Busy, o_Grant_Request;
    logic          o_Mem_Read_En, o_Mem_Write_En, o_RF_Write_En, o_RF_Read_En, o_PU_Start;
    logic [AW-1:0] o_Mem_Address;
    logic [RW-1:0] o_RF_Address;
`ifdef PU_WATCHDOG_EN
    logic          o_Error;
`endif

    block_mac_sequencer #(
        .K(K), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .MU_WIDTH(MW), .RF_ADDR_WIDTH(RW)
`ifdef PU_WATCHDOG_EN
        , .WATCHDOG_CYCLES(16)
`endif
    ) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_Indexes_Ready(i_Indexes_Ready), .i_Row_Index(i_Row_Index), .i_Column_Index(i_Column_Index),
        .i_mu(i_mu), .i_Blocks_Per_Row(i_Blocks_Per_Row),
        .i_A_Base(i_A_Base), .i_B_Base(i_B_Base), .i_C_Base(i_C_Base),
        .o_Indexes_Received(o_Indexes_Received), .o_Result_Ready(o_Result_Ready), .o_Busy(o_Busy),
        .o_Grant_Request(o_Grant_Request), .i_Grant(i_Grant),
        .o_Mem_Read_En(o_Mem_Read_En), .o_Mem_Write_En(o_Mem_Write_En), .o_Mem_Address(o_Mem_Address),
        .o_RF_Write_En(o_RF_Write_En), .o_RF_Read_En(o_RF_Read_En), .o_RF_Address(o_RF_Address),
        .o_PU_Start(o_PU_Start),
`ifdef PU_WATCHDOG_EN
        .o_Error(o_Error),
`endif
        .i_PU_Done(i_PU_Done)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observed event streams, sampled on the falling edge.
    int rd_q[$], rfw_q[$], wr_q[$], rfr_q[$];
    int n_ack, n_start, n_result, n_viol;
    bit prev_rd, prev_rfr;

    always @(negedge i_Clock) begin
        if (o_Mem_Read_En)  rd_q.push_back(int'(o_Mem_Address));
        if (o_RF_Write_En)  rfw_q.push_back(int'(o_RF_Address));
        if (o_Mem_Write_En) wr_q.push_back(int'(o_Mem_Address));
        if (o_RF_Read_En)   rfr_q.push_back(int'(o_RF_Address));
        if (o_Indexes_Received) n_ack++;
        if (o_PU_Start)     n_start++;
        if (o_Result_Ready) n_result++;
        if (!i_Reset) begin
            prev_rd  = 1'b0;
            prev_rfr = 1'b0;
        end else begin
            // RF write must follow a memory read by exactly one cycle; memory write likewise follows an RF read.
            if (o_RF_Write_En !== prev_rd)   n_viol++;
            if (o_Mem_Write_En !== prev_rfr) n_viol++;
            if ((o_Mem_Read_En || o_RF_Read_En) && !i_Grant) n_viol++;
            prev_rd  = o_Mem_Read_En;
            prev_rfr = o_RF_Read_En;
        end
    end

    // Grant driver: held, a 4-cycle drop once drop_at reads have been seen, or random.
    bit gnt_rand = 1'b0;
    int drop_at = -1;
    int drop_left = 0;
    initial begin
        i_Grant = 1'b0;
        forever begin
            @(posedge i_Clock); #1;
            if (drop_at >= 0 && rd_q.size() == drop_at) begin
                drop_left = 4;
                drop_at   = -1;
            end
            if (drop_left > 0) begin
                i_Grant = 1'b0;
                drop_left--;
            end else if (gnt_rand) begin
                i_Grant = ($urandom_range(0, 3) != 0);
            end else begin
                i_Grant = 1'b1;
            end
        end
    end

    // PU model: one-cycle done pulse pu_delay cycles after each start.
    bit pu_auto = 1'b1;
    int pu_delay = 5;
    initial begin
        i_PU_Done = 1'b0;
        forever begin
            @(negedge i_Clock);
            if (o_PU_Start && pu_auto) begin
                repeat (pu_delay) @(posedge i_Clock);
                #1 i_PU_Done = 1'b1;
                @(posedge i_Clock);
                #1 i_PU_Done = 1'b0;
            end
        end
    end

    // Reference model: expected address lists straight from the block-index arithmetic.
    int exp_rd[$], exp_rfw[$], exp_wr[$], exp_rfr[$];
    int exp_starts;
    bit hold_ready = 1'b0;

    function automatic int wrap(input int v);
        return v & ((1 << AW) - 1);
    endfunction

    task automatic build_expect(input int i, input int j, input int mu, input int bpr,
                                input int ab, input int bb, input int cb);
        int m;
        m = (mu == 0) ? 1 : mu;
        exp_rd.delete(); exp_rfw.delete(); exp_wr.delete(); exp_rfr.delete();
        for (int x = 0; x < m; x++) begin
            for (int p = 0; p < KK; p++) begin
                exp_rd.push_back(wrap(ab + (i * bpr + x) * KK + p));
                exp_rfw.push_back(p);
            end
            for (int p = 0; p < KK; p++) begin
                exp_rd.push_back(wrap(bb + (x * bpr + j) * KK + p));
                exp_rfw.push_back(KK + p);
            end
        end
        for (int p = 0; p < KK; p++) begin
            exp_wr.push_back(wrap(cb + (i * bpr + j) * KK + p));
            exp_rfr.push_back(p);
        end
        exp_starts = m;
    endtask

    task automatic start_job(input int i, input int j, input int mu, input int bpr,
                             input int ab, input int bb, input int cb);
        int t;
        t = 0;
        build_expect(i, j, mu, bpr, ab, bb, cb);
        rd_q.delete(); rfw_q.delete(); wr_q.delete(); rfr_q.delete();
        n_ack = 0; n_start = 0; n_result = 0; n_viol = 0;
        i_Row_Index      = IW'(i);
        i_Column_Index   = IW'(j);
        i_mu             = MW'(mu);
        i_Blocks_Per_Row = IW'(bpr);
        i_A_Base         = AW'(ab);
        i_B_Base         = AW'(bb);
        i_C_Base         = AW'(cb);
        i_Indexes_Ready  = 1'b1;
        do begin
            @(posedge i_Clock); #2;
            t++;
        end while (!o_Indexes_Received && t < 20);
        check("ack", 32'(o_Indexes_Received), 1);
        check("busy_after_ack", 32'(o_Busy), 1);
        if (!hold_ready) i_Indexes_Ready = 1'b0;
    endtask

    task automatic wait_result(input int budget);
        int t;
        t = 0;
        while (!o_Result_Ready && t < budget) begin
            @(posedge i_Clock); #2;
            t++;
        end
        i_Indexes_Ready = 1'b0;
        check("result_seen", 32'(o_Result_Ready), 1);
        @(posedge i_Clock); #2;
        check("idle_busy", 32'(o_Busy), 0);
        check("idle_gnt_req", 32'(o_Grant_Request), 0);
    endtask

    task automatic wait_start(input int budget);
        int t;
        t = 0;
        while (!o_PU_Start && t < budget) begin
            @(posedge i_Clock); #2;
            t++;
        end
        check("pu_start_seen", 32'(o_PU_Start), 1);
    endtask

    task automatic check_job();
        check("rd_count", rd_q.size(), exp_rd.size());
        foreach (exp_rd[k]) if (k < rd_q.size()) check($sformatf("rd_addr[%0d]", k), rd_q[k], exp_rd[k]);
        check("rfw_count", rfw_q.size(), exp_rfw.size());
        foreach (exp_rfw[k]) if (k < rfw_q.size()) check($sformatf("rfw_addr[%0d]", k), rfw_q[k], exp_rfw[k]);
        check("wr_count", wr_q.size(), exp_wr.size());
        foreach (exp_wr[k]) if (k < wr_q.size()) check($sformatf("wr_addr[%0d]", k), wr_q[k], exp_wr[k]);
        check("rfr_count", rfr_q.size(), exp_rfr.size());
        foreach (exp_rfr[k]) if (k < rfr_q.size()) check($sformatf("rfr_addr[%0d]", k), rfr_q[k], exp_rfr[k]);
        check("pu_starts", n_start, exp_starts);
        check("result_pulses", n_result, 1);
        check("acks", n_ack, 1);
        check("protocol_violations", n_viol, 0);
    endtask

    logic [31:0] outs;

    initial begin
        // Reset state
        repeat (3) @(posedge i_Clock);
        #2;
        outs = 32'({o_Indexes_Received, o_Result_Ready, o_Busy, o_Grant_Request, o_Mem_Read_En,
                    o_Mem_Write_En, o_Mem_Address, o_RF_Write_En, o_RF_Read_En, o_RF_Address, o_PU_Start});
        check("reset_outputs", outs, 0);
`ifdef PU_WATCHDOG_EN
        check("reset_error", 32'(o_Error), 0);
`endif
        i_Reset = 1'b1;
        @(posedge i_Clock); #2;

        // 1: single-x job, grant held, PU done after 5 cycles
        pu_delay = 5;
        start_job(1, 0, 1, 3, 0, 100, 600);
        wait_result(500);
        check_job();
        check("t1_first_a", rd_q[0], 12);
        check("t1_first_b", rd_q[4], 100);
        check("t1_first_c", wr_q[0], 612);

        // 2: mu=3, ready held through the job must not be re-acknowledged
        hold_ready = 1'b1;
        start_job(0, 2, 3, 3, 0, 100, 600);
        hold_ready = 1'b0;
        wait_result(1000);
        check_job();
        check("t2_b_x0", rd_q[4], 108);
        check("t2_b_x1", rd_q[12], 120);
        check("t2_b_x2", rd_q[20], 132);

        // 3: grant dropped for 4 cycles just before A word p=2
        drop_at = 2;
        start_job(1, 1, 1, 3, 40, 200, 700);
        wait_result(500);
        check_job();
        check("t3_resume_p2", rd_q[2], 54);

        // Done pulse coincident with o_PU_Start is ignored
        pu_auto = 1'b0;
        start_job(2, 1, 1, 4, 8, 300, 500);
        wait_start(200);
        i_PU_Done = 1'b1;
        @(posedge i_Clock); #1 i_PU_Done = 1'b0;
        repeat (3) @(posedge i_Clock);
        #2;
        check("early_done_still_busy", 32'(o_Busy), 1);
        check("early_done_no_request", 32'(o_Grant_Request), 0);
        i_PU_Done = 1'b1;
        @(posedge i_Clock); #1 i_PU_Done = 1'b0;
        wait_result(300);
        check_job();
        pu_auto = 1'b1;

        // 4: async reset while in FETCH_B
        start_job(1, 0, 1, 3, 0, 100, 600);
        begin
            int t;
            t = 0;
            while (rd_q.size() < KK + 2 && t < 200) begin
                @(posedge i_Clock); #2;
                t++;
            end
        end
        check("t4_in_fetch_b", 32'(o_Mem_Read_En), 1);
        i_Reset = 1'b0;
        #1;
        outs = 32'({o_Indexes_Received, o_Result_Ready, o_Busy, o_Grant_Request, o_Mem_Read_En,
                    o_Mem_Write_En, o_Mem_Address, o_RF_Write_En, o_RF_Read_En, o_RF_Address, o_PU_Start});
        check("t4_outputs_in_reset", outs, 0);
        rd_q.delete(); rfw_q.delete();
        repeat (3) @(posedge i_Clock);
        #2;
        check("t4_no_reads_in_reset", rd_q.size(), 0);
        check("t4_no_rf_writes_in_reset", rfw_q.size(), 0);
        i_Reset = 1'b1;
        @(posedge i_Clock); #2;
        start_job(2, 2, 2, 3, 16, 400, 800);
        wait_result(800);
        check_job();

        // 5: mu=0 acts as mu=1, addresses wrap past 1023
        start_job(0, 0, 0, 1, 1022, 1020, 1023);
        wait_result(500);
        check_job();
        check("t5_wrap_a", rd_q[2], 0);
        check("t5_wrap_c", wr_q[1], 0);

`ifdef PU_WATCHDOG_EN
        // 6: PU never finishes; watchdog aborts after 16 PU_RUN cycles
        pu_auto = 1'b0;
        start_job(1, 0, 1, 3, 0, 100, 600);
        wait_start(200);
        repeat (16) @(posedge i_Clock);
        #2;
        check("wd_no_error_yet", 32'(o_Error), 0);
        check("wd_still_busy", 32'(o_Busy), 1);
        @(posedge i_Clock); #2;
        check("wd_error", 32'(o_Error), 1);
        check("wd_idle", 32'(o_Busy), 0);
        check("wd_no_request", 32'(o_Grant_Request), 0);
        repeat (3) @(posedge i_Clock);
        #2;
        check("wd_no_result", n_result, 0);
        check("wd_error_sticky", 32'(o_Error), 1);
        pu_auto = 1'b1;
        start_job(1, 0, 1, 3, 0, 100, 600);
        check("wd_error_cleared", 32'(o_Error), 0);
        wait_result(500);
        check_job();
`endif

        // Randomized jobs with random grant and PU delay
        gnt_rand = 1'b1;
        for (int n = 0; n < 6; n++) begin
            pu_delay = $urandom_range(1, 8);
            start_job($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4),
                      $urandom_range(0, 255), $urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(0, 1023));
            wait_result(3000);
            check_job();
        end
        gnt_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
